// File: rtl/fp_norm_round_pipe.sv
// fp_norm_round_pipe
// Three-stage normalise / round / pack stage between the MAC adder tree and
// result writeback. Takes a sign-magnitude accumulator sum with its exponent
// context and produces a (1, EXP_W, MAN_W) floating-point word. The stages
// use valid/ready handshakes.
//   S1: leading-one detect, zero detect, signed exponent.
//   S2: normalising shift, subnormal shift, guard/sticky extraction.
//   S3: round (truncate or nearest-even), overflow/underflow, pack.
// Build option FP_NORM_SATURATE_EN: an overflow returns the largest finite
// value instead of infinity. The overflow flag is still raised.
module fp_norm_round_pipe #(
    parameter int EXP_W   = 5,
    parameter int MAN_W   = 10,
    parameter int SUM_W   = 22,
    parameter int MAXE_W  = 6,
    parameter int QF_W    = 5,
    parameter int EXP_OFS = 10,
    parameter int CNT_W   = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic                   in_sign,
    input  logic [SUM_W-1:0]       in_mag,
    input  logic [MAXE_W-1:0]      in_max_exp,
    input  logic [QF_W-1:0]        in_q_frac,
    input  logic                   rnd_mode,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [EXP_W+MAN_W:0]   out_data,
    output logic [2:0]             out_flags,
    output logic [CNT_W-1:0]       ovf_cnt,
    input  logic                   cnt_clr,
    output logic [50:0]            number
);

    // NW is the working width. It is at least hidden bit + mantissa + guard +
    // one sticky bit, so that short sums are zero-padded below the leading one.
    localparam int NW      = (SUM_W > MAN_W + 2) ? SUM_W : MAN_W + 3;
    localparam int LW      = $clog2(NW);
    localparam int EW      = MAXE_W + 3;
    localparam int SW      = EW + MAN_W;
    localparam int EXP_MAX = (1 << EXP_W) - 1;

    // Constant tally of the cells this structure instantiates:
    // flops, adder bits and shifter/detector mux bits.
    localparam int FLOP_CELLS  = (1 + 1 + NW + LW + 1 + EW + 1)
                               + (1 + 1 + 1 + 1 + EW + MAN_W + 2)
                               + (1 + 1 + EXP_W + MAN_W + 3)
                               + CNT_W;
    localparam int ARITH_CELLS = 3 * EW + EW + SW + CNT_W;
    localparam int MUX_CELLS   = NW * LW + 2 * NW * (LW + 1) + NW;
    localparam int CELL_TOTAL  = FLOP_CELLS + ARITH_CELLS + MUX_CELLS;

    // ------------------------------------------------------------------
    // Handshake: a stage may load when it is empty or its content leaves.
    // ------------------------------------------------------------------
    logic r_v1, r_v2, r_out_valid;
    logic w_rdy1, w_rdy2, w_rdy3;

    assign w_rdy3   = !r_out_valid || out_ready;
    assign w_rdy2   = !r_v2 || w_rdy3;
    assign w_rdy1   = !r_v1 || w_rdy2;
    assign in_ready = w_rdy1;

    // ------------------------------------------------------------------
    // Stage 1: leading one, zero detect, exponent
    // ------------------------------------------------------------------
    logic [NW-1:0]        w_mag_ext;
    logic [LW-1:0]        w_lead;
    logic                 w_zero;
    logic signed [EW-1:0] w_exp;

    assign w_mag_ext = NW'(in_mag);
    assign w_zero    = (in_mag == '0);
    // E = max_exp + L - q_frac - EXP_OFS, evaluated in EW bits so it cannot wrap.
    assign w_exp     = EW'(in_max_exp) + EW'(w_lead) - EW'(in_q_frac) - EW'(EXP_OFS);

    // Priority scan: the highest set bit of the magnitude wins.
    always_comb begin
        // NOTE: the default is assigned before the loop, so every path assigns
        // w_lead and no latch is inferred.
        w_lead = '0;
        for (int i = 0; i < NW; i++) begin
            if (w_mag_ext[i]) begin
                w_lead = LW'(i);
            end
        end
    end

    logic                 r_sign1, r_zero1, r_rnd1;
    logic [NW-1:0]        r_mag1;
    logic [LW-1:0]        r_lead1;
    logic signed [EW-1:0] r_exp1;

    // Stage valid bits: each stage takes its upstream valid whenever it may load.
    always_ff @(posedge clk) begin
        // NOTE: use non-blocking assignments for all registers. Every stage
        // then samples pre-edge values and the pipeline shifts as one.
        if (rst) begin
            r_v1 <= 1'b0;
            r_v2 <= 1'b0;
        end else begin
            if (w_rdy1) r_v1 <= in_valid;
            if (w_rdy2) r_v2 <= r_v1;
        end
    end

    // Stage 1 payload capture on an accepted input beat.
    always_ff @(posedge clk) begin
        // NOTE: payload registers have no reset. The valid bits alone qualify
        // them, and a flushed pipe never exposes stale payload.
        if (w_rdy1 && in_valid) begin
            r_sign1 <= in_sign;
            r_mag1  <= w_mag_ext;
            r_lead1 <= w_lead;
            r_zero1 <= w_zero;
            r_exp1  <= w_exp;
            r_rnd1  <= rnd_mode;
        end
    end

    // ------------------------------------------------------------------
    // Stage 2: normalise, denormalise, guard/sticky
    // ------------------------------------------------------------------
    logic [NW-1:0]   w_norm;
    logic            w_sub;
    logic [EW-1:0]   w_dist;
    logic [LW:0]     w_shamt;
    logic [2*NW-1:0] w_wide;
    logic [NW-1:0]   w_den;
    logic            w_lost;
    logic [MAN_W-1:0] w_man2;
    logic            w_g2, w_s2;
    logic [EW-1:0]   w_ep2;

    // Bring the leading one to the top. For E <= 0, shift right by a further
    // 1-E (capped at NW). Bits that fall off the bottom fold into sticky.
    always_comb begin
        w_norm  = r_mag1 << (LW'(NW - 1) - r_lead1);
        w_sub   = r_exp1[EW-1] || (r_exp1 == '0);
        w_dist  = EW'(1) - r_exp1;
        w_shamt = '0;
        if (w_sub) begin
            w_shamt = (w_dist > EW'(NW)) ? (LW+1)'(NW) : w_dist[LW:0];
        end
        w_wide  = {w_norm, {NW{1'b0}}} >> w_shamt;
        w_den   = w_wide[2*NW-1 -: NW];
        w_lost  = |w_wide[NW-1:0];
        w_man2  = w_den[NW-2 -: MAN_W];
        w_g2    = w_den[NW-2-MAN_W];
        w_s2    = (|w_den[NW-3-MAN_W:0]) || w_lost;
        // The exponent field is E only while the hidden one is still in
        // place. A subnormal has shifted it out, so its field is 0.
        w_ep2   = w_den[NW-1] ? r_exp1 : '0;
    end

    logic             r_sign2, r_zero2, r_rnd2, r_g2, r_s2;
    logic [EW-1:0]    r_ep2;
    logic [MAN_W-1:0] r_man2;

    // Stage 2 payload capture when stage 1 content advances.
    always_ff @(posedge clk) begin
        if (w_rdy2 && r_v1) begin
            r_sign2 <= r_sign1;
            r_zero2 <= r_zero1;
            r_rnd2  <= r_rnd1;
            r_ep2   <= w_ep2;
            r_man2  <= w_man2;
            r_g2    <= w_g2;
            r_s2    <= w_s2;
        end
    end

    // ------------------------------------------------------------------
    // Stage 3: round, range check, pack
    // ------------------------------------------------------------------
    logic                 w_inc, w_ovf, w_unf, w_inx;
    logic [SW-1:0]        w_sum;
    logic [EW-1:0]        w_fexp;
    logic [MAN_W-1:0]     w_fman;
    logic [EXP_W+MAN_W:0] w_data3;
    logic [2:0]           w_flags3;

    // Exponent and mantissa are rounded as one number. A mantissa carry then
    // moves subnormal to min normal, or normal to the next binade.
    always_comb begin
        w_inc   = r_rnd2 && r_g2 && (r_s2 || r_man2[0]);
        w_sum   = {r_ep2, r_man2} + SW'(w_inc);
        w_fexp  = w_sum[SW-1:MAN_W];
        w_fman  = w_sum[MAN_W-1:0];
        w_ovf   = !r_zero2 && (w_fexp >= EW'(EXP_MAX));
        w_inx   = !r_zero2 && (r_g2 || r_s2 || w_ovf);
        w_unf   = 1'b0;
        w_data3 = {r_sign2, w_fexp[EXP_W-1:0], w_fman};
        if (r_zero2) begin
            w_data3 = {r_sign2, {(EXP_W + MAN_W){1'b0}}};
        end else if (w_ovf) begin
`ifdef FP_NORM_SATURATE_EN
            w_data3 = {r_sign2, {(EXP_W - 1){1'b1}}, 1'b0, {MAN_W{1'b1}}};
`else
            w_data3 = {r_sign2, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
`endif
        end else begin
            w_unf = w_inx && (w_fexp == '0);
        end
        w_flags3 = {w_ovf, w_unf, w_inx};
    end

    logic [EXP_W+MAN_W:0] r_out_data;
    logic [2:0]           r_out_flags;

    // Output register. It holds steady while the consumer stalls.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_flags <= '0;
        end else if (w_rdy3) begin
            r_out_valid <= r_v2;
            if (r_v2) begin
                r_out_data  <= w_data3;
                r_out_flags <= w_flags3;
            end
        end
    end

    // ------------------------------------------------------------------
    // Overflow event counter: delivered overflows only, saturating.
    // ------------------------------------------------------------------
    logic [CNT_W-1:0] r_ovf_cnt;

    // Clear wins over a same-cycle increment.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ovf_cnt <= '0;
        end else if (cnt_clr) begin
            r_ovf_cnt <= '0;
        end else if (r_out_valid && out_ready && r_out_flags[2] && (r_ovf_cnt != '1)) begin
            r_ovf_cnt <= r_ovf_cnt + CNT_W'(1);
        end
    end

    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;
    assign out_flags = r_out_flags;
    assign ovf_cnt   = r_ovf_cnt;
    assign number    = 51'(CELL_TOTAL);

endmodule

// File: tb/tb_fp_norm_round_pipe.sv
// tb_fp_norm_round_pipe
// Directed bench for fp_norm_round_pipe with default parameters.
// Expected words are worked out by hand from the operand fields.
// Define FP_NORM_SATURATE_EN for both bench and design to check the saturating build.
module tb_fp_norm_round_pipe;

`ifdef FP_NORM_SATURATE_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif
    // Overflow body without sign: max finite when saturating, else infinity.
    localparam logic [14:0] OVF_BODY = SAT ? 15'h7BFF : 15'h7C00;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic        in_sign;
    logic [21:0] in_mag;
    logic [5:0]  in_max_exp;
    logic [4:0]  in_q_frac;
    logic        rnd_mode;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_data;
    logic [2:0]  out_flags;
    logic [15:0] ovf_cnt;
    logic        cnt_clr;
    logic [50:0] number;

    int n_tests = 0;
    int n_fail  = 0;
    int exp_cnt = 0;

    fp_norm_round_pipe dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_sign    (in_sign),
        .in_mag     (in_mag),
        .in_max_exp (in_max_exp),
        .in_q_frac  (in_q_frac),
        .rnd_mode   (rnd_mode),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .out_flags  (out_flags),
        .ovf_cnt    (ovf_cnt),
        .cnt_clr    (cnt_clr),
        .number     (number)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_tests++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    // One beat through an idle pipe with out_ready high. The result must
    // appear exactly 3 edges after acceptance and be gone the edge after.
    task automatic send_one(input string tag, input logic s, input logic [21:0] mag,
                            input logic [5:0] mx, input logic [4:0] qf, input logic rm,
                            input logic [15:0] exp_d, input logic [2:0] exp_f);
        in_valid   = 1'b1;
        in_sign    = s;
        in_mag     = mag;
        in_max_exp = mx;
        in_q_frac  = qf;
        rnd_mode   = rm;
        step();
        in_valid = 1'b0;
        in_mag   = '0;
        step();
        check({tag, ".early"}, out_valid, 1'b0);
        step();
        check({tag, ".valid"}, out_valid, 1'b1);
        check({tag, ".data"}, out_data, exp_d);
        check({tag, ".flags"}, out_flags, exp_f);
        if (exp_f[2]) exp_cnt++;
        step();
        check({tag, ".cnt"}, ovf_cnt, exp_cnt);
        check({tag, ".gone"}, out_valid, 1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int sent, rx, first_c, last_c;

        rst        = 1'b1;
        in_valid   = 1'b0;
        in_sign    = 1'b0;
        in_mag     = '0;
        in_max_exp = '0;
        in_q_frac  = '0;
        rnd_mode   = 1'b0;
        out_ready  = 1'b1;
        cnt_clr    = 1'b0;
        repeat (3) step();
        rst = 1'b0;
        step();
        check("rst.in_ready", in_ready, 1'b1);
        check("rst.out_valid", out_valid, 1'b0);
        check("rst.out_data", out_data, 16'h0000);
        check("rst.out_flags", out_flags, 3'b000);
        check("rst.ovf_cnt", ovf_cnt, 16'h0000);

        // L=10, E=15: 1.0
        send_one("basic", 1'b0, 22'h000400, 6'd15, 5'd0, 1'b0, 16'h3C00, 3'b000);
        send_one("basic_neg", 1'b1, 22'h000400, 6'd15, 5'd0, 1'b0, 16'hBC00, 3'b000);
        // L=2, mantissa zero-padded below the leading one: 1.25
        send_one("short_mag", 1'b0, 22'h000005, 6'd23, 5'd0, 1'b0, 16'h3D00, 3'b000);
        // L=12, E=15, man=0x200
        send_one("rne_tie_even", 1'b0, 22'h001802, 6'd13, 5'd0, 1'b1, 16'h3E00, 3'b001);
        send_one("rne_1803", 1'b0, 22'h001803, 6'd13, 5'd0, 1'b1, 16'h3E01, 3'b001);
        send_one("rne_1807", 1'b0, 22'h001807, 6'd13, 5'd0, 1'b1, 16'h3E02, 3'b001);
        send_one("trunc_1807", 1'b0, 22'h001807, 6'd13, 5'd0, 1'b0, 16'h3E01, 3'b001);
        // Mantissa all ones + round -> next binade (exp 16 -> 17)
        send_one("carry_binade", 1'b0, 22'h000FFF, 6'd15, 5'd0, 1'b1, 16'h4400, 3'b001);
        // E=0 subnormal
        send_one("sub_half", 1'b0, 22'h000400, 6'd1, 5'd1, 1'b0, 16'h0200, 3'b000);
        send_one("sub_to_norm", 1'b0, 22'h0007FF, 6'd0, 5'd0, 1'b1, 16'h0400, 3'b001);
        send_one("sub_trunc", 1'b0, 22'h0007FF, 6'd0, 5'd0, 1'b0, 16'h03FF, 3'b011);
        // E=-10: hidden one lands exactly on guard
        send_one("sub_guard_tie", 1'b0, 22'h000400, 6'd0, 5'd10, 1'b1, 16'h0000, 3'b011);
        send_one("sub_guard_up", 1'b0, 22'h000401, 6'd0, 5'd10, 1'b1, 16'h0001, 3'b011);
        // E=-11 and E=-12: everything goes to sticky
        send_one("sub_all_sticky", 1'b0, 22'h000400, 6'd0, 5'd11, 1'b1, 16'h0000, 3'b011);
        send_one("sub_zero", 1'b0, 22'h000401, 6'd0, 5'd12, 1'b1, 16'h0000, 3'b011);
        send_one("zero", 1'b1, 22'h000000, 6'd63, 5'd0, 1'b1, 16'h8000, 3'b000);
        // E=74
        send_one("ovf_max", 1'b1, 22'h3FFFFF, 6'd63, 5'd0, 1'b0, {1'b1, OVF_BODY}, 3'b101);
        // E=30, man all ones: truncation stays finite, rounding overflows
        send_one("below_ovf", 1'b0, 22'h000FFF, 6'd29, 5'd0, 1'b0, 16'h7BFF, 3'b001);
        send_one("ovf_round", 1'b0, 22'h000FFF, 6'd29, 5'd0, 1'b1, {1'b0, OVF_BODY}, 3'b101);
        // E=31 exactly
        send_one("ovf_exact", 1'b0, 22'h000400, 6'd31, 5'd0, 1'b0, {1'b0, OVF_BODY}, 3'b101);

        // Clear coinciding with an overflow transfer: clear wins.
        in_valid   = 1'b1;
        in_sign    = 1'b0;
        in_mag     = 22'h3FFFFF;
        in_max_exp = 6'd63;
        in_q_frac  = 5'd0;
        rnd_mode   = 1'b0;
        step();
        in_valid = 1'b0;
        step();
        step();
        check("clr.pre_valid", out_valid, 1'b1);
        check("clr.pre_flags", out_flags, 3'b101);
        check("clr.pre_cnt", ovf_cnt, exp_cnt);
        cnt_clr = 1'b1;
        step();
        cnt_clr = 1'b0;
        exp_cnt = 0;
        check("clr.cnt", ovf_cnt, 16'h0000);
        send_one("ovf_after_clr", 1'b1, 22'h3FFFFF, 6'd63, 5'd0, 1'b1, {1'b1, OVF_BODY}, 3'b101);

        // Backpressure: 6 beats with exponents 15..20, consumer stalled for
        // cycles 0..6. The pipe fills after 3 beats, then drains in order.
        sent    = 0;
        rx      = 0;
        first_c = -1;
        last_c  = -1;
        for (int c = 0; c < 40 && rx < 6; c++) begin
            out_ready  = (c >= 7);
            in_valid   = (sent < 6);
            in_sign    = 1'b0;
            in_mag     = 22'h000400;
            in_max_exp = 6'(15 + sent);
            in_q_frac  = 5'd0;
            rnd_mode   = 1'b0;
            #1;
            if (c == 3) check("bp.held_beats", sent, 3);
            if (c >= 3 && c <= 6) begin
                check("bp.in_ready_low", in_ready, 1'b0);
                check("bp.hold_valid", out_valid, 1'b1);
                check("bp.hold_data", out_data, 16'h3C00);
            end
            if (out_valid && out_ready) begin
                check("bp.order", out_data, 32'h3C00 + 32'(rx) * 32'h400);
                rx++;
                if (first_c < 0) first_c = c;
                last_c = c;
            end
            if (in_valid && in_ready) sent++;
            step();
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        check("bp.sent", sent, 6);
        check("bp.received", rx, 6);
        check("bp.no_bubble", last_c - first_c, 5);
        step();
        check("bp.drained", out_valid, 1'b0);

        // Reset with beats in flight: everything discarded, counter cleared.
        in_valid   = 1'b1;
        in_mag     = 22'h3FFFFF;
        in_max_exp = 6'd63;
        step();
        step();
        rst = 1'b1;
        step();
        rst      = 1'b0;
        in_valid = 1'b0;
        check("mrst.out_valid", out_valid, 1'b0);
        check("mrst.in_ready", in_ready, 1'b1);
        check("mrst.out_data", out_data, 16'h0000);
        check("mrst.out_flags", out_flags, 3'b000);
        check("mrst.ovf_cnt", ovf_cnt, 16'h0000);
        exp_cnt = 0;
        repeat (4) step();
        check("mrst.quiet", out_valid, 1'b0);
        send_one("post_rst", 1'b0, 22'h000400, 6'd15, 5'd0, 1'b0, 16'h3C00, 3'b000);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
